// File: rtl/sevenseg_scan_decoder_if.sv
// Frame snapshot handshake between the scan decoder (master) and its consumer (slave).
interface sevenseg_scan_decoder_if #(
    parameter int N_DIGITS = 4
) ();
    logic [4*N_DIGITS-1:0] frame_bcd;
    logic [N_DIGITS-1:0]   frame_dp;
    logic [N_DIGITS-1:0]   frame_invalid;
    logic                  frame_valid;
    logic                  frame_ready;

    modport master (
        output frame_bcd,
        output frame_dp,
        output frame_invalid,
        output frame_valid,
        input  frame_ready
    );

    modport slave (
        input  frame_bcd,
        input  frame_dp,
        input  frame_invalid,
        input  frame_valid,
        output frame_ready
    );
endinterface

// File: rtl/sevenseg_scan_decoder.sv
// Decodes a scanned 7-segment anode/cathode bus back into per-digit BCD, dp and validity.
// Optional hex digit decoding (A..F) is enabled by defining SEVENSEG_HEX_EN.
module sevenseg_scan_decoder #(
    parameter int N_DIGITS       = 4,
    parameter int STABLE_CYCLES  = 4,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [N_DIGITS-1:0]   an_in,
    input  logic [7:0]            seg_in,
    output logic [4*N_DIGITS-1:0] live_bcd,
    output logic [N_DIGITS-1:0]   live_dp,
    output logic [N_DIGITS-1:0]   live_invalid,
    output logic                  anode_err,
    sevenseg_scan_decoder_if.master frame_if
);

    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);

    logic [N_DIGITS-1:0] an_samp_q, an_prev_q;
    logic [7:0]          seg_samp_q, seg_prev_q;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [N_DIGITS-1:0] seen_q, seen_d;
    logic                frame_valid_q, frame_valid_d;
    logic                anode_err_q;

    logic [N_DIGITS-1:0] an_act;
    logic                one_hot, multi, same, commit, frame_take;
    logic [N_DIGITS-1:0] commit_vec;
    logic [7:0]          seg_act;
    logic [4:0]          dec;

    // Returns {invalid, code}; gfedcba active-high.
    function automatic logic [4:0] decode_seg(input logic [6:0] p);
        case (p)
            7'h3F:   return {1'b0, 4'h0};
            7'h06:   return {1'b0, 4'h1};
            7'h5B:   return {1'b0, 4'h2};
            7'h4F:   return {1'b0, 4'h3};
            7'h66:   return {1'b0, 4'h4};
            7'h6D:   return {1'b0, 4'h5};
            7'h7D:   return {1'b0, 4'h6};
            7'h07:   return {1'b0, 4'h7};
            7'h7F:   return {1'b0, 4'h8};
            7'h6F:   return {1'b0, 4'h9};
`ifdef SEVENSEG_HEX_EN
            7'h77:   return {1'b0, 4'hA};
            7'h7C:   return {1'b0, 4'hB};
            7'h39:   return {1'b0, 4'hC};
            7'h5E:   return {1'b0, 4'hD};
            7'h79:   return {1'b0, 4'hE};
            7'h71:   return {1'b0, 4'hF};
`endif
            default: return {1'b1, 4'hF};
        endcase
    endfunction

    always_comb begin
        an_act  = ~an_samp_q;
        one_hot = (an_act != '0) && ((an_act & (an_act - N_DIGITS'(1))) == '0);
        multi   = (an_act != '0) && !one_hot;
        same    = (an_samp_q == an_prev_q) && (seg_samp_q == seg_prev_q);
        seg_act = SEG_ACTIVE_LOW ? ~seg_samp_q : seg_samp_q;
        dec     = decode_seg(seg_act[6:0]);
        cnt_d   = '0;
        commit  = 1'b0;
        if (one_hot) begin
            if (same)
                cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CW'(1);
            else
                cnt_d = CW'(1);
            // A run that is already saturated has committed; only a fresh arrival commits.
            commit = (cnt_d == CNT_MAX) && !(same && (cnt_q == CNT_MAX));
        end
        commit_vec = commit ? an_act : '0;
    end

    always_comb begin
        frame_take    = (&seen_q) && (!frame_valid_q || frame_if.frame_ready);
        seen_d        = (frame_take ? '0 : seen_q) | commit_vec;
        frame_valid_d = frame_valid_q;
        if (frame_take)
            frame_valid_d = 1'b1;
        else if (frame_valid_q && frame_if.frame_ready)
            frame_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            an_samp_q     <= '1;
            an_prev_q     <= '1;
            seg_samp_q    <= '0;
            seg_prev_q    <= '0;
            cnt_q         <= '0;
            seen_q        <= '0;
            frame_valid_q <= 1'b0;
            anode_err_q   <= 1'b0;
        end else begin
            an_samp_q     <= an_in;
            seg_samp_q    <= seg_in;
            an_prev_q     <= an_samp_q;
            seg_prev_q    <= seg_samp_q;
            cnt_q         <= cnt_d;
            seen_q        <= seen_d;
            frame_valid_q <= frame_valid_d;
            anode_err_q   <= multi;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_digit
            logic [3:0] bcd_q, fbcd_q;
            logic       dp_q, fdp_q, inv_q, finv_q;

            // Snapshot takes the pre-commit live values of this edge.
            always_ff @(posedge clk) begin
                if (!reset) begin
                    bcd_q  <= 4'h0;
                    dp_q   <= 1'b0;
                    inv_q  <= 1'b1;
                    fbcd_q <= 4'h0;
                    fdp_q  <= 1'b0;
                    finv_q <= 1'b1;
                end else begin
                    if (commit_vec[gi]) begin
                        bcd_q <= dec[3:0];
                        dp_q  <= seg_act[7];
                        inv_q <= dec[4];
                    end
                    if (frame_take) begin
                        fbcd_q <= bcd_q;
                        fdp_q  <= dp_q;
                        finv_q <= inv_q;
                    end
                end
            end

            assign live_bcd[4*gi +: 4]          = bcd_q;
            assign live_dp[gi]                  = dp_q;
            assign live_invalid[gi]             = inv_q;
            assign frame_if.frame_bcd[4*gi +: 4] = fbcd_q;
            assign frame_if.frame_dp[gi]        = fdp_q;
            assign frame_if.frame_invalid[gi]   = finv_q;
        end
    endgenerate

    assign frame_if.frame_valid = frame_valid_q;
    assign anode_err            = anode_err_q;

endmodule

// File: tb/tb_sevenseg_scan_decoder.sv
// Self-checking bench for sevenseg_scan_decoder: expected frames are queued as scans are driven.
module tb_sevenseg_scan_decoder;

    localparam int N = 4;

    logic           clk;
    logic           reset;
    logic [N-1:0]   an_in;
    logic [7:0]     seg_in;
    logic [4*N-1:0] live_bcd;
    logic [N-1:0]   live_dp;
    logic [N-1:0]   live_invalid;
    logic           anode_err;

    sevenseg_scan_decoder_if #(.N_DIGITS(N)) frame_if ();

    sevenseg_scan_decoder #(
        .N_DIGITS(N),
        .STABLE_CYCLES(4),
        .SEG_ACTIVE_LOW(1'b1)
    ) dut (
        .clk(clk),
        .reset(reset),
        .an_in(an_in),
        .seg_in(seg_in),
        .live_bcd(live_bcd),
        .live_dp(live_dp),
        .live_invalid(live_invalid),
        .anode_err(anode_err),
        .frame_if(frame_if)
    );

    typedef struct {
        logic [15:0] bcd;
        logic [3:0]  dp;
        logic [3:0]  inv;
    } frame_t;

    frame_t exp_q[$];
    int     tests_run = 0;
    int     tests_failed = 0;

    logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_digit(input int idx, input logic [6:0] pat, input logic dp, input int n);
        logic [N-1:0] sel;
        sel    = N'(1) << idx;
        an_in  = ~sel;
        seg_in = ~{dp, pat};
        repeat (n) tick();
    endtask

    task automatic blank(input int n);
        an_in  = '1;
        seg_in = 8'hFF;
        repeat (n) tick();
    endtask

    task automatic scan4(input logic [3:0] d0, input logic [3:0] d1, input logic [3:0] d2,
                         input logic [3:0] d3, input logic [3:0] dpm);
        frame_t f;
        f.bcd = {d3, d2, d1, d0};
        f.dp  = dpm;
        f.inv = 4'h0;
        exp_q.push_back(f);
        drive_digit(0, seg_tab[d0], dpm[0], 6);
        drive_digit(1, seg_tab[d1], dpm[1], 6);
        drive_digit(2, seg_tab[d2], dpm[2], 6);
        drive_digit(3, seg_tab[d3], dpm[3], 6);
        blank(2);
    endtask

    task automatic wait_frame();
        int n = 0;
        while (frame_if.frame_valid !== 1'b1 && n < 200) begin
            tick();
            n++;
        end
        check_value("frame_wait", {31'b0, frame_if.frame_valid}, 32'd1);
    endtask

    task automatic expect_frame();
        frame_t f;
        if (exp_q.size() == 0) begin
            check_value("sb_nonempty", 32'd0, 32'd1);
        end else begin
            f = exp_q.pop_front();
            $display("[TB] frame bcd=%h dp=%b inv=%b (expected bcd=%h dp=%b inv=%b)",
                     frame_if.frame_bcd, frame_if.frame_dp, frame_if.frame_invalid,
                     f.bcd, f.dp, f.inv);
            check_value("frame_bcd", {16'b0, frame_if.frame_bcd}, {16'b0, f.bcd});
            check_value("frame_dp", {28'b0, frame_if.frame_dp}, {28'b0, f.dp});
            check_value("frame_inv", {28'b0, frame_if.frame_invalid}, {28'b0, f.inv});
        end
    endtask

    task automatic ready_pulse();
        frame_if.frame_ready = 1'b1;
        tick();
        frame_if.frame_ready = 1'b0;
    endtask

    initial begin
        reset                = 1'b0;
        an_in                = '1;
        seg_in               = 8'hFF;
        frame_if.frame_ready = 1'b0;
        repeat (3) tick();
        check_value("rst_live_bcd", {16'b0, live_bcd}, 32'h0);
        check_value("rst_live_dp", {28'b0, live_dp}, 32'h0);
        check_value("rst_live_inv", {28'b0, live_invalid}, 32'hF);
        check_value("rst_frame_bcd", {16'b0, frame_if.frame_bcd}, 32'h0);
        check_value("rst_frame_inv", {28'b0, frame_if.frame_invalid}, 32'hF);
        check_value("rst_frame_valid", {31'b0, frame_if.frame_valid}, 32'h0);
        check_value("rst_anode_err", {31'b0, anode_err}, 32'h0);

        // Single digit: commit lands after exactly 5 edges
        reset  = 1'b1;
        an_in  = 4'b1110;
        seg_in = ~8'h5B;
        repeat (4) tick();
        check_value("latency_not_yet", {31'b0, live_invalid[0]}, 32'h1);
        tick();
        check_value("d0_bcd", {28'b0, live_bcd[3:0]}, 32'h2);
        check_value("d0_inv", {31'b0, live_invalid[0]}, 32'h0);
        $display("[TB] single digit 0 -> bcd=%h", live_bcd[3:0]);

        // Too short a run must not commit
        drive_digit(1, 7'h06, 1'b0, 3);
        blank(3);
        check_value("short_bcd", {28'b0, live_bcd[7:4]}, 32'h0);
        check_value("short_inv", {31'b0, live_invalid[1]}, 32'h1);

        // Full scan with consumer stalled
        scan4(4'h1, 4'h2, 4'h3, 4'h4, 4'b0010);
        wait_frame();
        expect_frame();
        scan4(4'h8, 4'h8, 4'h8, 4'h8, 4'b0000);
        check_value("hold_frame_bcd", {16'b0, frame_if.frame_bcd}, 32'h4321);
        check_value("hold_frame_valid", {31'b0, frame_if.frame_valid}, 32'h1);
        check_value("live_8888", {16'b0, live_bcd}, 32'h8888);
        ready_pulse();
        wait_frame();
        expect_frame();
        ready_pulse();
        check_value("consumed_valid", {31'b0, frame_if.frame_valid}, 32'h0);

        // Two anodes active at once
        an_in  = 4'b1100;
        seg_in = ~8'h7F;
        tick();
        tick();
        check_value("anode_err_on", {31'b0, anode_err}, 32'h1);
        an_in  = '1;
        seg_in = 8'hFF;
        tick();
        tick();
        check_value("anode_err_off", {31'b0, anode_err}, 32'h0);
        check_value("anode_no_change", {16'b0, live_bcd}, 32'h8888);
        scan4(4'h5, 4'h6, 4'h7, 4'h9, 4'b1000);
        wait_frame();
        expect_frame();
        ready_pulse();

        // Hex pattern A
        drive_digit(0, 7'h77, 1'b0, 6);
        blank(1);
`ifdef SEVENSEG_HEX_EN
        check_value("hex_bcd", {28'b0, live_bcd[3:0]}, 32'hA);
        check_value("hex_inv", {31'b0, live_invalid[0]}, 32'h0);
`else
        check_value("hex_bcd", {28'b0, live_bcd[3:0]}, 32'hF);
        check_value("hex_inv", {31'b0, live_invalid[0]}, 32'h1);
`endif
        $display("[TB] pattern 77 -> bcd=%h inv=%b", live_bcd[3:0], live_invalid[0]);

        // Reset while a frame is pending
        scan4(4'h0, 4'h9, 4'h1, 4'h8, 4'b0101);
        wait_frame();
        expect_frame();
        reset = 1'b0;
        tick();
        check_value("mid_rst_valid", {31'b0, frame_if.frame_valid}, 32'h0);
        check_value("mid_rst_inv", {28'b0, live_invalid}, 32'hF);
        check_value("mid_rst_bcd", {16'b0, live_bcd}, 32'h0);
        check_value("mid_rst_frame_bcd", {16'b0, frame_if.frame_bcd}, 32'h0);
        reset = 1'b1;
        blank(4);
        check_value("post_rst_valid", {31'b0, frame_if.frame_valid}, 32'h0);
        check_value("sb_drained", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
